// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the video SRAM arbiter.
// Access sequencing states and the owner tag of the access in flight.
package vram_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 14;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_VID_DEPTH  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_VID = 1'b0,
      OWN_CPU = 1'b1
   } owner_t;

endpackage

// File: rtl/vram_vid_fifo.sv
// Small power-of-two FIFO holding queued video fetch addresses.
// A push into a full FIFO is dropped and latches a sticky overflow flag.
module vram_vid_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [PW:0]      count;
   logic             doPush;
   logic             doPop;

   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);
   assign doPop  = pop && !empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO still fits.
   assign doPush = push && (!full || doPop);
   assign dout   = mem[rdPtr];

   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr] <= din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !doPush) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one asynchronous video SRAM between the ULA fetch unit (absolute
// priority) and the CPU, using two-cycle SETUP/STROBE accesses.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int VID_DEPTH  = DEF_VID_DEPTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  vidReq,
   input  logic                  vidPage,
   input  logic [ADDR_WIDTH-2:0] vidAddr,
   output logic [DATA_WIDTH-1:0] vidData,
   output logic                  vidValid,
   output logic                  vidOverflow,
   input  logic                  cpuReq,
   input  logic                  cpuWr,
   input  logic [ADDR_WIDTH-1:0] cpuAddr,
   input  logic [DATA_WIDTH-1:0] cpuDi,
   output logic [DATA_WIDTH-1:0] cpuDo,
   output logic                  cpuAck,
   output logic [ADDR_WIDTH-1:0] memAddr,
   input  logic [DATA_WIDTH-1:0] memDi,
   output logic [DATA_WIDTH-1:0] memDo,
   output logic                  memOe,
   output logic                  memWe
);

   // CPU handshake: cpuReq is a level held (with stable cpuWr/cpuAddr/cpuDi)
   // until the one-cycle cpuAck pulse; the requester drops it afterwards.
   // Video requests are fire-and-forget strobes answered by one vidValid pulse each.

   state_t                state;
   state_t                nextState;
   owner_t                owner;
   logic                  curWr;
   logic                  decision;
   logic                  vidPending;
   logic                  cpuBlock;
   logic                  grantVid;
   logic                  grantCpu;
   logic                  fifoPush;
   logic                  fifoPop;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic [ADDR_WIDTH-1:0] fifoHead;
   logic [ADDR_WIDTH-1:0] vidReqAddr;
   logic [ADDR_WIDTH-1:0] vidGrantAddr;

   assign vidReqAddr   = {vidPage, vidAddr};
   assign decision     = (state == IDLE) || (state == STROBE);
   assign vidPending   = !fifoEmpty || vidReq;
   // Keeps a request that is being acknowledged from being granted a second time.
   assign cpuBlock     = ((state == STROBE) && (owner == OWN_CPU)) || cpuAck;
   assign grantVid     = decision && vidPending;
   assign grantCpu     = decision && !vidPending && cpuReq && !cpuBlock;
   assign vidGrantAddr = fifoEmpty ? vidReqAddr : fifoHead;
   assign fifoPop      = grantVid && !fifoEmpty;
   // An empty FIFO with a request at a decision point bypasses storage.
   assign fifoPush     = vidReq && !(grantVid && fifoEmpty);

   vram_vid_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (VID_DEPTH)
   ) vidFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifoPush),
      .pop      (fifoPop),
      .din      (vidReqAddr),
      .dout     (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .overflow (vidOverflow)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = (grantVid || grantCpu) ? SETUP : IDLE;
         SETUP:   nextState = STROBE;
         STROBE:  nextState = (grantVid || grantCpu) ? SETUP : IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Decoded straight from the state register so reset removes memWe at once.
   always_comb begin
      memOe = ((state == SETUP) || (state == STROBE)) && !curWr;
      memWe = (state == STROBE) && curWr;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner    <= OWN_VID;
         curWr    <= 1'b0;
         memAddr  <= '0;
         memDo    <= '0;
         vidData  <= '0;
         vidValid <= 1'b0;
         cpuDo    <= '0;
         cpuAck   <= 1'b0;
      end else begin
         if (grantVid) begin
            owner   <= OWN_VID;
            curWr   <= 1'b0;
            memAddr <= vidGrantAddr;
         end else if (grantCpu) begin
            owner   <= OWN_CPU;
            curWr   <= cpuWr;
            memAddr <= cpuAddr;
            if (cpuWr) memDo <= cpuDi;
         end
         vidValid <= (state == STROBE) && (owner == OWN_VID);
         cpuAck   <= (state == STROBE) && (owner == OWN_CPU);
         if (state == STROBE) begin
            if (owner == OWN_VID)  vidData <= memDi;
            else if (!curWr)       cpuDo   <= memDi;
         end
      end
   end

   logic unusedFull;
   assign unusedFull = fifoFull;

endmodule
